mont_mul_arbiter: RTL and testbench
===================================

// Module: mont_mul_arbiter
// PURPOSE
//  Shares one Montgomery multiplier between N_REQ requesters, e.g. two CRT exponentiation
//  engines or the exponentiation FSM plus a pre/post-processing unit. Round-robin grant,
//  one operation in flight, operands latched so requesters may change inputs after acceptance.
//  Sits between the requesters and the single mont-mul instance under the RSA wrapper.
// PARAMETERS
//  N_REQ           2      number of requesters (2..4)
//  WIDTH           1024   operand/result width in bits
//  TIMEOUT_CYCLES  4096   watchdog limit in WAIT; used only with MM_TIMEOUT_EN
// PORTS
//  clk         in   1            clock, all logic on posedge
//  resetn      in   1            reset, synchronous, active-low
//  req_valid   in   N_REQ        requester i has an operation pending
//  req_ready   out  N_REQ        one-hot accept; handshake = valid & ready, same cycle
//  req_a       in   N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b       in   N_REQ*WIDTH  operand B, same packing
//  req_m       in   N_REQ*WIDTH  modulus, same packing
//  rsp_valid   out  N_REQ        one-hot: result for requester i is on rsp_result
//  rsp_ready   in   N_REQ        requester i consumes the result
//  rsp_result  out  WIDTH        shared result bus, stable while any rsp_valid is high
//  rsp_err     out  1            qualifies rsp_valid: timeout; constant 0 without macro
//  mm_start    out  1            one-cycle start pulse to the multiplier
//  mm_a/mm_b/mm_m out WIDTH      latched operands, stable from ISSUE until RESP exit
//  mm_done     in   1            multiplier completion pulse, mm_result valid that cycle
//  mm_result   in   WIDTH        multiplier output
//  busy        out  1            state != IDLE
//  grant_id    out  2            index of current/last grant
// BEHAVIOUR
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: g = first i with req_valid[i], searched from (ptr+1) mod N_REQ upward.
//    req_ready = onehot(g), combinational, asserted only in IDLE. On the handshake, latch
//    a/b/m[g] into mm_*, set grant_id=g, go to ISSUE. No req_valid: stay, req_ready=0.
//  - ISSUE: mm_start=1 for exactly this cycle, go to WAIT. mm_done here is ignored.
//  - WAIT: on mm_done, latch mm_result into rsp_result, go to RESP.
//  - RESP: rsp_valid[g]=1 until rsp_ready[g]. Then ptr<=g, go to IDLE. rsp_ready of other
//    requesters is ignored.
//  - Minimum accept-to-rsp_valid latency: multiplier latency L + 2 cycles. IDLE re-arbitrates
//    the cycle after RESP exits, so a constantly requesting pair alternates strictly.
//  - Requests arriving in ISSUE/WAIT/RESP get ready=0 and must hold valid (no drop).
//  - N_REQ=1: degenerate fixed grant, same FSM.
//  - Reset (any state, incl. mid-WAIT): state=IDLE, ptr=N_REQ-1 (requester 0 wins first),
//    req_ready=0, rsp_valid=0, mm_start=0, rsp_err=0, busy=0, grant_id=0,
//    mm_*=0, rsp_result=0. Any in-flight op is discarded, since the multiplier shares resetn.
// CONFIGURATION
//  MM_TIMEOUT_EN defined: a 16-bit counter clears on ISSUE and increments in WAIT. When it
//    reaches TIMEOUT_CYCLES without mm_done: go to RESP with rsp_err=1, rsp_result=0.
//    rsp_err clears on RESP exit. A late mm_done outside WAIT is ignored.
//  Not defined: no counter, rsp_err tied 0, WAIT waits indefinitely.
// STRUCTURE
//  rsa_pkg: RSA_WIDTH=1024 and the state localparams
//    (ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2, ARB_RESP=2'd3).
//  Sub-module rr_picker (combinational): in req[N_REQ], ptr; out one-hot gnt, index.
//    Reused by any later multi-engine scheduler.
// TESTING (stub multiplier: result=(a*b)%m after L=10 cycles; WIDTH=16 bench instance)
//  1 Single req0 a=3,b=5,m=7 -> req_ready[0] same cycle, one mm_start, rsp_valid[0] 12 cycles
//    after accept, rsp_result=1.
//  2 req0 and req1 both valid from reset -> grant order 0,1,0,1 over 4 ops,
//    never two concurrent mm_start.
//  3 Hold rsp_ready[0]=0 for 20 cycles -> rsp_valid[0], rsp_result stable; req1 not accepted.
//  4 Change req_a[0] to 9 after accept -> mm_a stays 3, result still 1.
//  5 Assert resetn=0 for 1 cycle mid-WAIT -> next cycle all outputs at reset values;
//    a new req1 is then accepted and completes.
//  6 MM_TIMEOUT_EN, TIMEOUT_CYCLES=50, stub never raises mm_done -> rsp_valid with rsp_err=1
//    after 50 WAIT cycles. Without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants for the RSA datapath: default operand width and the
// mont-mul arbiter state encoding.
package rsa_pkg;

    localparam int RSA_WIDTH = 1024;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mont_mul_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1 (mod N), returned as a one-hot grant plus its index.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [1:0]   index
);

    logic found_s;
    int   idx_s;

    // Scan the N rotated positions, keeping the first hit.
    always_comb begin
        gnt     = '0;
        index   = 2'd0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 1; k <= N; k++) begin
            idx_s = (int'(ptr) + k) % N;
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                index      = 2'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Round-robin share of one Montgomery multiplier between N_REQ requesters,
// one operation in flight. Optional watchdog in WAIT under MM_TIMEOUT_EN.
module mont_mul_arbiter
    import rsa_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int WIDTH          = RSA_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*WIDTH-1:0] req_m,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_err,
    output logic                   mm_start,
    output logic [WIDTH-1:0]       mm_a,
    output logic [WIDTH-1:0]       mm_b,
    output logic [WIDTH-1:0]       mm_m,
    input  logic                   mm_done,
    input  logic [WIDTH-1:0]       mm_result,
    output logic                   busy,
    output logic [1:0]             grant_id
);

    arb_state_e       state_r, state_nx_s;
    logic [1:0]       ptr_r, grant_id_r, pick_idx_s;
    logic [N_REQ-1:0] pick_gnt_s, gnt_oh_s;
    logic [WIDTH-1:0] mm_a_r, mm_b_r, mm_m_r, rsp_result_r;
    logic [WIDTH-1:0] sel_a_s, sel_b_s, sel_m_s;
    logic             rsp_err_r, hs_s, rsp_take_s, timeout_s;

    rr_picker #(.N(N_REQ)) u_picker (
        .req   (req_valid),
        .ptr   (ptr_r),
        .gnt   (pick_gnt_s),
        .index (pick_idx_s)
    );

    // Ready only in IDLE, and never while reset is asserted.
    always_comb begin
        if ((state_r == ARB_IDLE) && resetn) begin
            req_ready = pick_gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    // Operand mux for the granted requester and one-hot of the latched grant.
    always_comb begin
        sel_a_s  = '0;
        sel_b_s  = '0;
        sel_m_s  = '0;
        gnt_oh_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s     = sel_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{pick_gnt_s[i]}});
            sel_b_s     = sel_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{pick_gnt_s[i]}});
            sel_m_s     = sel_m_s | (req_m[i*WIDTH +: WIDTH] & {WIDTH{pick_gnt_s[i]}});
            gnt_oh_s[i] = (grant_id_r == 2'(i));
        end
    end

    assign hs_s       = |(req_valid & req_ready);
    assign rsp_take_s = |(rsp_valid & rsp_ready);

`ifdef MM_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;

    // Watchdog: cleared while issuing, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == ARB_ISSUE) begin
            tmo_cnt_r <= 16'd0;
        end else if (state_r == ARB_WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end
    end

    assign timeout_s = (state_r == ARB_WAIT) && !mm_done &&
                       (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo_s;
    assign unused_tmo_s = (TIMEOUT_CYCLES == 0);
    assign timeout_s    = 1'b0;
`endif

    // Next-state logic; mm_done outside WAIT is deliberately ignored.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (hs_s) state_nx_s = ARB_ISSUE;
                else      state_nx_s = ARB_IDLE;
            end
            ARB_ISSUE: state_nx_s = ARB_WAIT;
            ARB_WAIT: begin
                if (mm_done || timeout_s) state_nx_s = ARB_RESP;
                else                      state_nx_s = ARB_WAIT;
            end
            ARB_RESP: begin
                if (rsp_take_s) state_nx_s = ARB_IDLE;
                else            state_nx_s = ARB_RESP;
            end
            default: state_nx_s = ARB_IDLE;
        endcase
    end

    // State, grant pointer, latched operands and response registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ARB_IDLE;
            ptr_r        <= 2'(N_REQ - 1);
            grant_id_r   <= 2'd0;
            mm_a_r       <= '0;
            mm_b_r       <= '0;
            mm_m_r       <= '0;
            rsp_result_r <= '0;
            rsp_err_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ARB_IDLE: begin
                    if (hs_s) begin
                        mm_a_r     <= sel_a_s;
                        mm_b_r     <= sel_b_s;
                        mm_m_r     <= sel_m_s;
                        grant_id_r <= pick_idx_s;
                    end
                end
                ARB_WAIT: begin
                    if (mm_done) begin
                        rsp_result_r <= mm_result;
                    end else if (timeout_s) begin
                        rsp_result_r <= '0;
                        rsp_err_r    <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    if (rsp_take_s) begin
                        ptr_r     <= grant_id_r;
                        rsp_err_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mm_start   = (state_r == ARB_ISSUE);
    assign busy       = (state_r != ARB_IDLE);
    assign rsp_valid  = (state_r == ARB_RESP) ? gnt_oh_s : '0;
    assign rsp_result = rsp_result_r;
    assign rsp_err    = rsp_err_r;
    assign mm_a       = mm_a_r;
    assign mm_b       = mm_b_r;
    assign mm_m       = mm_m_r;
    assign grant_id   = grant_id_r;

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Randomized bench for mont_mul_arbiter (N_REQ=2, WIDTH=16) with a 10-cycle
// stub multiplier and a transaction-level reference model.
module tb_mont_mul_arbiter;

    localparam int W = 16;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0, req_m = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W-1:0]   rsp_result;
    logic           rsp_err, mm_start, mm_done, busy;
    logic [W-1:0]   mm_a, mm_b, mm_m, mm_result;
    logic [1:0]     grant_id;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    mont_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_m(req_m),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_done(mm_done), .mm_result(mm_result),
        .busy(busy), .grant_id(grant_id)
    );

    // Stub multiplier: done pulse 10 cycles after the start is sampled.
    logic       hang = 1'b0;
    logic [3:0] stub_cnt;
    logic [W-1:0] stub_res;
    always @(posedge clk) begin
        if (!resetn) begin
            stub_cnt <= 4'd0;
            mm_done  <= 1'b0;
            stub_res <= '0;
        end else begin
            mm_done <= 1'b0;
            if (mm_start && !hang) begin
                stub_cnt <= 4'd10;
                stub_res <= W'((32'(mm_a) * 32'(mm_b)) % 32'(mm_m));
            end else if (stub_cnt == 4'd1) begin
                mm_done  <= 1'b1;
                stub_cnt <= 4'd0;
            end else if (stub_cnt != 4'd0) begin
                stub_cnt <= stub_cnt - 4'd1;
            end
        end
    end
    assign mm_result = stub_res;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction at a time, round-robin from last served.
    logic [N-1:0] hs_seen = '0;
    logic         rst_smp;
    bit           m_busy = 1'b0;
    int           m_last = N - 1;
    int           m_g, m_k, g;
    logic [W-1:0] ea, eb, em;
    logic [N-1:0] ev;
    logic         eerr;
    longint       eres;

    always begin
        @(posedge clk);
        rst_smp = resetn;
        @(negedge clk);
        if (!rst_smp) begin
            m_busy = 1'b0;
            m_last = N - 1;
            check_eq("rst_ctl", 64'({busy, mm_start, rsp_valid, rsp_err, grant_id}), 64'd0);
            check_eq("rst_data", 64'({mm_a, mm_b, mm_m, rsp_result}), 64'd0);
        end
        if (!resetn) begin
            check_eq("rst_ready", 64'(req_ready), 64'd0);
        end else if (!m_busy) begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            end
            check_eq("idle_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
            check_eq("idle_ctl", 64'({busy, mm_start, rsp_valid}), 64'd0);
            if (g >= 0) begin
                m_busy = 1'b1;
                m_g    = g;
                m_k    = -1;
                ea     = req_a[g*W +: W];
                eb     = req_b[g*W +: W];
                em     = req_m[g*W +: W];
            end
        end else begin
            m_k++;
            check_eq("busy_ctl", 64'({busy, req_ready}), 64'({1'b1, 2'b00}));
            check_eq("mm_start", 64'(mm_start), 64'(m_k == 0));
            if (m_k == 0) begin
                check_eq("grant_id", 64'(grant_id), 64'(m_g));
                check_eq("mm_ops", 64'({mm_a, mm_b, mm_m}), 64'({ea, eb, em}));
            end
            ev   = '0;
            eerr = 1'b0;
            eres = (longint'(ea) * longint'(eb)) % longint'(em);
            if (!hang && m_k >= 12) ev = N'(1) << m_g;
`ifdef MM_TIMEOUT_EN
            if (hang && m_k >= 51) begin
                ev   = N'(1) << m_g;
                eerr = 1'b1;
                eres = 0;
            end
`endif
            check_eq("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (ev != '0) begin
                check_eq("rsp_result", 64'(rsp_result), 64'(eres));
                check_eq("rsp_err", 64'(rsp_err), 64'(eerr));
                check_eq("mm_a_hold", 64'(mm_a), 64'(ea));
                if ((ev & rsp_ready) != '0) begin
                    m_busy = 1'b0;
                    m_last = m_g;
                end
            end
        end
        hs_seen = resetn ? (req_valid & req_ready) : '0;
    end

    // Requesters: drop valid after acceptance (and disturb operand A),
    // optionally raise a new request; rsp_ready randomized.
    task automatic drive_cycles(input int n, input int req_pct, input int rdy_pct);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_seen[i]) begin
                    req_valid[i]     = 1'b0;
                    req_a[i*W +: W]  = 16'd9;
                end else if (!req_valid[i] && ($urandom_range(99) < req_pct)) begin
                    req_a[i*W +: W]  = 16'($urandom);
                    req_b[i*W +: W]  = 16'($urandom);
                    req_m[i*W +: W]  = 16'($urandom_range(65535, 1));
                    req_valid[i]     = 1'b1;
                end
                rsp_ready[i] = ($urandom_range(99) < rdy_pct);
            end
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        // Single request 3*5 mod 7, operand changed after accept
        req_a[W-1:0] = 16'd3;
        req_b[W-1:0] = 16'd5;
        req_m[W-1:0] = 16'd7;
        req_valid    = 2'b01;
        rsp_ready    = 2'b11;
        drive_cycles(25, 0, 100);
        // Both requesters continuously busy: strict alternation
        drive_cycles(70, 100, 100);
        // Long response stall while the other requester waits
        drive_cycles(45, 100, 0);
        drive_cycles(40, 100, 100);
        // Random traffic
        drive_cycles(1500, 30, 60);
        drive_cycles(40, 0, 100);
        // Reset in the middle of WAIT, then a fresh req1
        req_a[W-1:0] = 16'($urandom);
        req_b[W-1:0] = 16'($urandom);
        req_m[W-1:0] = 16'd101;
        req_valid    = 2'b01;
        drive_cycles(6, 0, 100);
        reset_pulse();
        req_a[W +: W] = 16'd12;
        req_b[W +: W] = 16'd34;
        req_m[W +: W] = 16'd55;
        req_valid     = 2'b10;
        drive_cycles(30, 0, 100);
        // Multiplier never completes
        hang          = 1'b1;
        req_valid     = 2'b01;
        drive_cycles(120, 0, 100);
        reset_pulse();
        hang = 1'b0;
        drive_cycles(30, 50, 100);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
